// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

  // Scan phase: GUARD keeps every anode off, SHOW lights one digit.
  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/lz_blank_mask.sv
// Per-digit suppression mask: a digit goes dark when disabled, or when
// leading-zero suppression is on and it and every digit above it is zero.
// Digit 0 is never zero-suppressed so a value of zero still shows "0".
module lz_blank_mask
  import display_pkg::*;
(
  input  logic [15:0]           snapshot,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic                  lz_suppress,
  output logic [NUM_DIGITS-1:0] suppress
);

  logic zero_3;
  logic zero_32;
  logic zero_321;

  // Zero-run detection from the most significant digit downward.
  always_comb begin
    zero_3   = (snapshot[15:12] == 4'h0);
    zero_32  = zero_3 && (snapshot[11:8] == 4'h0);
    zero_321 = zero_32 && (snapshot[7:4] == 4'h0);

    suppress[0] = ~digit_en[0];
    suppress[1] = ~digit_en[1] | (lz_suppress & zero_321);
    suppress[2] = ~digit_en[2] | (lz_suppress & zero_32);
    suppress[3] = ~digit_en[3] | (lz_suppress & zero_3);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scanner: walks a digit index through GUARD/SHOW
// windows, drives active-low anodes and feeds a shared external decoder.
// The value is captured once per frame so a frame never mixes two values.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int GUARD_TICKS     = 1000,
  parameter int CNT_W           = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  lz_suppress,
  output logic [NUM_DIGITS-1:0] an,
  output logic [3:0]            n,
  output logic                  blank,
  output logic                  dp,
  output logic [1:0]            digit_idx,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_TICKS - 1);

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           snap_q, snap_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            n_q, n_d;
  logic                  blank_q, blank_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic [NUM_DIGITS-1:0] suppress;

  // Suppression is judged against the snapshot that the next cycle displays.
  lz_blank_mask u_lz_blank_mask (
    .snapshot    (snap_d),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .suppress    (suppress)
  );

  // Next-state: tick counter, GUARD/SHOW sequencing, digit walk, snapshot.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + CNT_W'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;

    // Capture at the very start of a frame (first GUARD cycle of digit 0).
    if (state_q == GUARD && idx_q == 2'd0 && tick_q == '0) begin
      snap_d = value;
    end

    case (state_q)
      GUARD: begin
        if (tick_q == GUARD_LAST) begin
          state_d = SHOW;
          tick_d  = '0;
        end
      end
      SHOW: begin
        if (tick_q == SHOW_LAST) begin
          state_d = GUARD;
          tick_d  = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = GUARD;
        tick_d  = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    an_d    = AN_ALL_OFF;
    n_d     = 4'h0;
    blank_d = 1'b1;
    dp_d    = 1'b1;
    fd_d    = 1'b0;

    if (state_d == SHOW) begin
      n_d  = snap_d[{idx_d, 2'b00} +: 4];
      fd_d = (idx_d == 2'd3) && (tick_d == SHOW_LAST);
      if (!suppress[idx_d]) begin
        an_d    = ~(4'b0001 << idx_d);
        blank_d = 1'b0;
        dp_d    = ~dp_in[idx_d];
      end
    end
  end

  // State, counter, snapshot and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GUARD;
      tick_q  <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      an_q    <= AN_ALL_OFF;
      n_q     <= 4'h0;
      blank_q <= 1'b1;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      n_q     <= n_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign n          = n_q;
  assign blank      = blank_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with TICKS_PER_DIGIT=4, GUARD_TICKS=1.
// Cycle 1 is the cycle right after reset is released; outputs sampled on negedge.
module tb_display_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic        lz_suppress;
  logic [3:0]  an;
  logic [3:0]  n;
  logic        blank;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int vecs;
  int errs;
  int cyc;

  display_scan_ctrl #(
    .TICKS_PER_DIGIT (4),
    .GUARD_TICKS     (1),
    .CNT_W           (17)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .an          (an),
    .n           (n),
    .blank       (blank),
    .dp          (dp),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Hold reset for two edges, then release at a negedge: that is cycle 1.
  task automatic apply_reset(input logic [15:0] v);
    reset = 1'b1;
    value = v;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if ({an, blank, dp, digit_idx, frame_done} !== {4'b1111, 1'b1, 1'b1, 2'd0, 1'b0}) begin
        errs++;
        $display("FAIL reset[%0d]: an=%b blank=%b dp=%b idx=%0d fd=%b, want 1111 1 1 0 0",
                 i, an, blank, dp, digit_idx, frame_done);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] exp_an [1:20];
    logic [3:0] exp_n  [1:20];
    logic [1:0] exp_i  [1:20];
    exp_an = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
               4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101,
               4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
               4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
    exp_n  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h3, 4'h3, 4'h3, 4'h3,
               4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
    exp_i  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
               2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    apply_reset(16'h1234);
    for (int c = 1; c <= 20; c++) begin
      run_to(c);
      vecs++;
      if (an !== exp_an[c] || digit_idx !== exp_i[c]) begin
        errs++;
        $display("FAIL scan_an c%0d: an=%b idx=%0d, want an=%b idx=%0d",
                 c, an, digit_idx, exp_an[c], exp_i[c]);
      end
      if (exp_an[c] != 4'b1111) begin
        vecs++;
        if (n !== exp_n[c] || blank !== 1'b0) begin
          errs++;
          $display("FAIL scan_n c%0d: n=%h blank=%b, want n=%h blank=0", c, n, blank, exp_n[c]);
        end
      end
    end
    apply_reset(16'h1234);
    for (int c = 1; c <= 60; c++) begin
      run_to(c);
      vecs++;
      if (frame_done !== ((c % 20) == 0)) begin
        errs++;
        $display("FAIL frame_done c%0d: got %b, want %b", c, frame_done, (c % 20) == 0);
      end
    end
  endtask

  task automatic test_lz_suppress();
    logic [3:0] want_an;
    int lit;
    lz_suppress = 1'b1;
    apply_reset(16'h0050);
    for (int c = 1; c <= 20; c++) begin
      run_to(c);
      want_an = (c >= 2 && c <= 5) ? 4'b1110 : (c >= 7 && c <= 10) ? 4'b1101 : 4'b1111;
      vecs++;
      if (an !== want_an) begin
        errs++;
        $display("FAIL lz_an c%0d: an=%b, want %b", c, an, want_an);
      end
      if (c == 3 || c == 8) begin
        vecs++;
        if (n !== ((c == 3) ? 4'h0 : 4'h5)) begin
          errs++;
          $display("FAIL lz_n c%0d: n=%h, want %h", c, n, (c == 3) ? 4'h0 : 4'h5);
        end
      end
    end
    apply_reset(16'h0000);
    lit = 0;
    for (int c = 1; c <= 20; c++) begin
      run_to(c);
      if (an == 4'b1110 && n == 4'h0) lit++;
      vecs++;
      if (an !== 4'b1111 && an !== 4'b1110) begin
        errs++;
        $display("FAIL lz_zero_an c%0d: an=%b, want 1111 or 1110", c, an);
      end
    end
    vecs++;
    if (lit !== 4) begin
      errs++;
      $display("FAIL lz_zero_lit: digit0 lit %0d cycles with n=0, want 4", lit);
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_frame_coherence();
    logic [3:0] want_n;
    apply_reset(16'h1234);
    run_to(8);
    value = 16'hABCD;
    for (int c = 13; c <= 38; c += 5) begin
      run_to(c);
      case (c)
        13:      want_n = 4'h2;
        18:      want_n = 4'h1;
        23:      want_n = 4'hD;
        28:      want_n = 4'hC;
        33:      want_n = 4'hB;
        default: want_n = 4'hA;
      endcase
      vecs++;
      if (n !== want_n || blank !== 1'b0) begin
        errs++;
        $display("FAIL coherence c%0d: n=%h blank=%b, want n=%h blank=0", c, n, blank, want_n);
      end
    end
  endtask

  task automatic test_enables_dp();
    digit_en = 4'b0000;
    dp_in    = 4'b1111;
    apply_reset(16'h1234);
    for (int c = 1; c <= 40; c++) begin
      run_to(c);
      vecs++;
      if (an !== 4'b1111 || dp !== 1'b1 || blank !== 1'b1 || frame_done !== ((c % 20) == 0)) begin
        errs++;
        $display("FAIL disabled c%0d: an=%b dp=%b blank=%b fd=%b, want 1111 1 1 %b",
                 c, an, dp, blank, frame_done, (c % 20) == 0);
      end
    end
    digit_en = 4'b1111;
    dp_in    = 4'b0100;
    apply_reset(16'h1234);
    for (int c = 1; c <= 20; c++) begin
      run_to(c);
      vecs++;
      if (dp !== ((an == 4'b1011) ? 1'b0 : 1'b1)) begin
        errs++;
        $display("FAIL dp c%0d: dp=%b with an=%b", c, dp, an);
      end
    end
    vecs++;
    run_to(23);
    if (dp !== 1'b1 || an !== 4'b1110) begin
      errs++;
      $display("FAIL dp_digit0: dp=%b an=%b, want dp=1 an=1110", dp, an);
    end
    dp_in = 4'b0000;
  endtask

  task automatic test_reset_mid();
    apply_reset(16'h1234);
    run_to(13);
    vecs++;
    if (an !== 4'b1011) begin
      errs++;
      $display("FAIL mid_pre: an=%b, want 1011", an);
    end
    value = 16'h5678;
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (an !== 4'b1111 || blank !== 1'b1 || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: an=%b blank=%b idx=%0d fd=%b, want 1111 1 0 0",
               an, blank, digit_idx, frame_done);
    end
    reset = 1'b0;
    cyc = 1;
    run_to(2);
    vecs++;
    if (an !== 4'b1110 || n !== 4'h8 || digit_idx !== 2'd0) begin
      errs++;
      $display("FAIL mid_restart: an=%b n=%h idx=%0d, want 1110 8 0", an, n, digit_idx);
    end
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    cyc         = 0;
    reset       = 1'b1;
    value       = 16'h0000;
    digit_en    = 4'b1111;
    dp_in       = 4'b0000;
    lz_suppress = 1'b0;
    test_reset();
    test_basic_scan();
    test_lz_suppress();
    test_frame_coherence();
    test_enables_dp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
